// File: rtl/exec_issue_ctrl.sv
// Issue controller between decode and execute: valid/ready handshake, load-use
// hold, multi-cycle MUL/DIV occupancy counter and a registered writeback tag.
module exec_issue_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [6:0] id_opcode,
  input  logic [2:0] id_funct3,
  input  logic [6:0] id_funct7,
  input  logic [4:0] id_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush_in,
  input  logic       mem_ready,
  output logic       ex_stall,
  output logic       ex_fire,
  output logic       md_busy,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       wb_write
);

  localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {RUN, MULDIV, HOLD} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            pend_ld, pend_ld_n;
  logic [4:0]      pend_rd, pend_rd_n;
  logic [4:0]      md_rd, md_rd_n;
  logic [4:0]      fire_rd;

  logic is_md, is_load, uses_rs1, uses_rs2, hazard;
  logic unused_funct3;

  assign unused_funct3 = ^id_funct3[1:0];

  assign is_md    = (id_opcode == OP_REG) && (id_funct7 == 7'b0000001);
  assign is_load  = (id_opcode == OP_LOAD);
  assign uses_rs1 = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) ||
                      (id_opcode == OP_JAL));
  assign uses_rs2 = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
                    (id_opcode == OP_BR);

  // A load writing x0 never creates a dependency.
  assign hazard = pend_ld && (pend_rd != 5'd0) &&
                  ((uses_rs1 && (id_rs1 == pend_rd)) ||
                   (uses_rs2 && (id_rs2 == pend_rd)));

  assign md_busy = (state == MULDIV) && !reset;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    pend_ld_n = pend_ld;
    pend_rd_n = pend_rd;
    md_rd_n   = md_rd;
    fire_rd   = md_rd;
    id_ready  = 1'b0;
    ex_fire   = 1'b0;
    ex_stall  = 1'b1;

    if (reset) begin
      state_n = RUN;
    end else if (flush_in) begin
      state_n   = RUN;
      cnt_n     = '0;
      pend_ld_n = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          id_ready  = !hazard && mem_ready;
          pend_ld_n = 1'b0;
          if (id_valid && id_ready) begin
            if (is_md) begin
              state_n = MULDIV;
              cnt_n   = id_funct3[2] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
              md_rd_n = id_rd;
            end else begin
              ex_fire   = 1'b1;
              ex_stall  = 1'b0;
              fire_rd   = id_rd;
              pend_ld_n = is_load;
              pend_rd_n = id_rd;
            end
          end else if (id_valid && hazard) begin
            state_n = HOLD;
          end
        end
        HOLD: state_n = RUN;
        MULDIV: begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else if (mem_ready) begin
            ex_fire  = 1'b1;
            ex_stall = 1'b0;
            state_n  = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      pend_ld  <= 1'b0;
      pend_rd  <= 5'd0;
      md_rd    <= 5'd0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_write <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend_ld  <= pend_ld_n;
      pend_rd  <= pend_rd_n;
      md_rd    <= md_rd_n;
      wb_valid <= ex_fire;
      wb_write <= ex_fire && (fire_rd != 5'd0);
      if (ex_fire) wb_rd <= fire_rd;
    end
  end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Self-checking bench for exec_issue_ctrl: table of single-cycle issue vectors,
// hand-written multi-cycle sequences, and a writeback scoreboard.
module tb_exec_issue_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic       clk, reset;
  logic       id_valid, id_ready;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       flush_in, mem_ready;
  logic       ex_stall, ex_fire, md_busy;
  logic       wb_valid, wb_write;
  logic [4:0] wb_rd;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
  } wb_t;
  wb_t sb_q[$];

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       mr, fl;
    logic       er, ef, es;
  } vec_t;

  exec_issue_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .flush_in(flush_in),
    .mem_ready(mem_ready), .ex_stall(ex_stall), .ex_fire(ex_fire),
    .md_busy(md_busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_write(wb_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback monitor: every tag pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_write", 32'(wb_write), 32'(e.wr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic mr, input logic fl);
    id_valid = v; id_opcode = op; id_funct3 = f3; id_funct7 = f7;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; mem_ready = mr; flush_in = fl;
  endtask

  task automatic idle(input logic mr, input logic fl);
    drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, mr, fl);
  endtask

  task automatic expect_push(input logic [4:0] rd);
    sb_q.push_back(wb_t'{rd, rd != 5'd0});
  endtask

  task automatic check_hs(input string tag, input logic r, input logic f, input logic s);
    check({tag, "_ready"}, 32'(id_ready), 32'(r));
    check({tag, "_fire"},  32'(ex_fire),  32'(f));
    check({tag, "_stall"}, 32'(ex_stall), 32'(s));
  endtask

  // Load followed by a dependent ADD: hazard cycle, one HOLD cycle, then accept.
  task automatic hazard_seq(input logic [4:0] ld_rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] dst);
    tick(); drive(1'b1, OP_LD, 3'b010, 7'd0, ld_rd, 5'd1, 5'd0, 1'b1, 1'b0); #1;
    check_hs("hz_load", 1'b1, 1'b1, 1'b0); expect_push(ld_rd);
    tick(); drive(1'b1, OP_R, 3'd0, 7'd0, dst, rs1, rs2, 1'b1, 1'b0); #1;
    check_hs("hz_detect", 1'b0, 1'b0, 1'b1);
    tick(); #1;
    check_hs("hz_hold", 1'b0, 1'b0, 1'b1);
    tick(); #1;
    check_hs("hz_accept", 1'b1, 1'b1, 1'b0); expect_push(dst);
    tick(); idle(1'b1, 1'b0);
  endtask

  vec_t tbl[17];

  function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                              input logic fl, input logic er, input logic ef, input logic es);
    return '{v: v, op: op, rd: rd, rs1: rs1, rs2: rs2, mr: mr, fl: fl,
             er: er, ef: ef, es: es};
  endfunction

  initial begin
    logic prev_fire;

    tbl[0]  = mk(1, OP_R,   5,  1,  2, 1, 0, 1, 1, 0);  // ADD x5
    tbl[1]  = mk(0, 7'd0,   0,  0,  0, 1, 0, 1, 0, 1);  // idle
    tbl[2]  = mk(1, OP_I,   0,  3,  0, 1, 0, 1, 1, 0);  // ADDI x0
    tbl[3]  = mk(1, OP_LD,  7,  1,  0, 1, 0, 1, 1, 0);  // LW x7
    tbl[4]  = mk(1, OP_R,   8,  1,  2, 1, 0, 1, 1, 0);  // ADD x8,x1,x2: independent
    tbl[5]  = mk(1, OP_LD,  9,  2,  0, 1, 0, 1, 1, 0);  // LW x9
    tbl[6]  = mk(1, OP_LUI, 10, 9,  9, 1, 0, 1, 1, 0);  // LUI ignores rs fields
    tbl[7]  = mk(1, OP_LD,  11, 1,  0, 1, 0, 1, 1, 0);  // LW x11
    tbl[8]  = mk(1, OP_I,   12, 1,  0, 0, 0, 0, 0, 1);  // mem not ready
    tbl[9]  = mk(1, OP_I,   12, 11, 0, 1, 0, 1, 1, 0);  // load pending already cleared
    tbl[10] = mk(1, OP_LD,  0,  1,  0, 1, 0, 1, 1, 0);  // LW x0
    tbl[11] = mk(1, OP_R,   13, 0,  0, 1, 0, 1, 1, 0);  // reads x0: no hazard
    tbl[12] = mk(1, OP_LD,  17, 1,  0, 1, 0, 1, 1, 0);  // LW x17
    tbl[13] = mk(1, OP_JAL, 1,  17, 17, 1, 0, 1, 1, 0); // JAL ignores rs fields
    tbl[14] = mk(1, OP_I,   14, 1,  0, 1, 1, 0, 0, 1);  // flush blocks accept
    tbl[15] = mk(1, OP_LD,  15, 2,  0, 1, 0, 1, 1, 0);  // LW x15
    tbl[16] = mk(1, OP_I,   16, 3, 15, 1, 0, 1, 1, 0);  // I-type ignores rs2

    // Reset behaviour
    reset = 1'b1;
    drive(1'b1, OP_R, 3'd0, 7'd0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
    tick(); #1;
    check_hs("rst", 1'b0, 1'b0, 1'b1);
    tick();
    reset = 1'b0; idle(1'b1, 1'b0); #1;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd",    32'(wb_rd),    32'd0);
    check("rst_wb_write", 32'(wb_write), 32'd0);
    check("rst_md_busy",  32'(md_busy),  32'd0);
    check("rst_run_ready", 32'(id_ready), 32'd1);

    // Table of single-cycle issue vectors, back to back
    prev_fire = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      drive(tbl[i].v, tbl[i].op, (tbl[i].op == OP_LD) ? 3'b010 : 3'b000, 7'd0,
            tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].mr, tbl[i].fl);
      #1;
      check_hs($sformatf("v%0d", i), tbl[i].er, tbl[i].ef, tbl[i].es);
      check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(prev_fire));
      if (tbl[i].ef) expect_push(tbl[i].rd);
      prev_fire = tbl[i].ef;
    end
    tick(); idle(1'b1, 1'b0);

    // Load-use hazards on rs1 and on rs2
    hazard_seq(5'd7, 5'd7, 5'd1, 5'd8);
    hazard_seq(5'd20, 5'd1, 5'd20, 5'd9);

    // DIV x3: busy for 32 cycles, fire in the last, tag the cycle after
    tick(); drive(1'b1, OP_R, 3'b100, F7_M, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0); #1;
    check_hs("div_accept", 1'b1, 1'b0, 1'b1);
    expect_push(5'd3);
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c == 1) idle(1'b1, 1'b0);
      #1;
      check($sformatf("div_c%0d_busy", c),  32'(md_busy),  32'(c <= 32));
      check($sformatf("div_c%0d_ready", c), 32'(id_ready), 32'(c == 33));
      check($sformatf("div_c%0d_fire", c),  32'(ex_fire),  32'(c == 32));
      check($sformatf("div_c%0d_stall", c), 32'(ex_stall), 32'(c != 32));
      check($sformatf("div_c%0d_wbv", c),   32'(wb_valid), 32'(c == 33));
    end

    // MUL x4 with mem_ready low in cycles 1..5
    tick(); drive(1'b1, OP_R, 3'b000, F7_M, 5'd4, 5'd1, 5'd2, 1'b1, 1'b0); #1;
    check_hs("mul_accept", 1'b1, 1'b0, 1'b1);
    expect_push(5'd4);
    for (int c = 1; c <= 7; c++) begin
      tick();
      idle(!(c >= 1 && c <= 5), 1'b0);
      #1;
      check($sformatf("mul_c%0d_fire", c), 32'(ex_fire),  32'(c == 6));
      check($sformatf("mul_c%0d_busy", c), 32'(md_busy),  32'(c <= 6));
      check($sformatf("mul_c%0d_wbv", c),  32'(wb_valid), 32'(c == 7));
    end

    // Reset in the middle of a MUL: no tag, everything cleared
    tick(); drive(1'b1, OP_R, 3'b000, F7_M, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0); #1;
    check_hs("mrst_accept", 1'b1, 1'b0, 1'b1);
    tick(); idle(1'b1, 1'b0); reset = 1'b1; #1;
    check_hs("mrst_in_reset", 1'b0, 1'b0, 1'b1);
    tick(); reset = 1'b0; #1;
    check("mrst_wb_valid", 32'(wb_valid), 32'd0);
    check("mrst_wb_rd",    32'(wb_rd),    32'd0);
    check("mrst_wb_write", 32'(wb_write), 32'd0);
    check("mrst_md_busy",  32'(md_busy),  32'd0);
    check("mrst_fire",     32'(ex_fire),  32'd0);
    check("mrst_ready",    32'(id_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      check($sformatf("mrst_after%0d_wbv", c), 32'(wb_valid), 32'd0);
    end

    // DIV flushed at cycle 10: back to RUN, no tag ever
    tick(); drive(1'b1, OP_R, 3'b101, F7_M, 5'd12, 5'd1, 5'd2, 1'b1, 1'b0); #1;
    check_hs("dflush_accept", 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      idle(1'b1, c == 10);
      #1;
    end
    check_hs("dflush_c10", 1'b0, 1'b0, 1'b1);
    check("dflush_c10_busy", 32'(md_busy), 32'd1);
    tick(); idle(1'b1, 1'b0); #1;
    check("dflush_c11_busy",  32'(md_busy),  32'd0);
    check("dflush_c11_ready", 32'(id_ready), 32'd1);
    for (int c = 12; c <= 40; c++) begin
      tick(); #1;
      check($sformatf("dflush_c%0d_wbv", c), 32'(wb_valid), 32'd0);
      check($sformatf("dflush_c%0d_fire", c), 32'(ex_fire), 32'd0);
    end

    // A tag registered just before a flush still pulses
    tick(); drive(1'b1, OP_R, 3'd0, 7'd0, 5'd21, 5'd1, 5'd2, 1'b1, 1'b0); #1;
    check_hs("fwb_add", 1'b1, 1'b1, 1'b0);
    expect_push(5'd21);
    tick(); drive(1'b1, OP_R, 3'd0, 7'd0, 5'd22, 5'd1, 5'd2, 1'b1, 1'b1); #1;
    check_hs("fwb_flush", 1'b0, 1'b0, 1'b1);
    check("fwb_wb_valid", 32'(wb_valid), 32'd1);
    tick(); idle(1'b1, 1'b0); #1;
    check("fwb_after_wbv", 32'(wb_valid), 32'd0);

    tick(); tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
